// File: rtl/hc21_int_ack_ctrl.sv
// hc21_int_ack_ctrl: Z80 mode-2 interrupt controller for STE attention requests 1..7.
// Synchronises the active-low attention lines and raises cpu_int_n for the highest masked
// request above the highest in-service level. It answers the M1+IORQ acknowledge cycle with
// the vector byte, tracks in-service levels for nesting and clears them on EOI writes.
//
// Ports:
//   sysclk, reset       system clock, synchronous active-high reset
//   atnrq_n[7:0]        attention requests, active low, asynchronous (bit 0 ignored)
//   cpu_addr[7:0]       CPU address
//   cpu_data_in[7:0]    CPU write data
//   cpu_m1_n/iorq_n/rd_n/wr_n  Z80 bus strobes, active low, synchronous to sysclk
//   cpu_data_out[7:0]   vector byte or register read data
//   cpu_data_oe         high while cpu_data_out must be driven onto the bus
//   cpu_int_n           Z80 INT, active low
//
// Registers: MASK at REG_BASE (r/w, bit 0 reads 0); ISR read / EOI write at REG_BASE+1.
// Build option HC21_INT_AUTO_EOI_EN: the in-service bit is cleared as the acknowledge
// cycle ends, and EOI writes are ignored.
module hc21_int_ack_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'h80,
    parameter logic [7:0] REG_BASE = 8'h20
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] atnrq_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_m1_n,
    input  logic       cpu_iorq_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    output logic [7:0] cpu_data_out,
    output logic       cpu_data_oe,
    output logic       cpu_int_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [7:0] REG_ISR = REG_BASE + 8'd1;

    // Index of the highest set bit among 7..1; 0 means none.
    function automatic logic [2:0] top_bit(input logic [7:0] v);
        logic [2:0] t;
        t = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (v[i]) t = i[2:0];
        end
        return t;
    endfunction

    logic [7:0] sync1_q, sync2_q;
    logic [7:0] mask_q, mask_d;
    logic [7:0] isr_q, isr_d;
    logic [1:0] state_q, state_d;
    logic [2:0] lvl_q, lvl_d;
    logic       io_wr_q;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;

    logic [7:0] req;
    logic [2:0] req_top, isr_top;
    logic       cand_valid;
    logic       ack, io_rd, io_wr, wr_start;
    logic       mask_sel, isr_sel;
    logic [7:0] isr_set, isr_clr;

    assign req        = ~sync2_q & mask_q & 8'hFE;
    assign req_top    = top_bit(req);
    assign isr_top    = top_bit(isr_q);
    // A request only interrupts when it outranks everything already in service.
    assign cand_valid = req_top > isr_top;

    assign ack      = ~cpu_m1_n & ~cpu_iorq_n;
    assign io_rd    = cpu_m1_n & ~cpu_iorq_n & ~cpu_rd_n;
    assign io_wr    = cpu_m1_n & ~cpu_iorq_n & ~cpu_wr_n;
    assign wr_start = io_wr & ~io_wr_q;
    assign mask_sel = cpu_addr == REG_BASE;
    assign isr_sel  = cpu_addr == REG_ISR;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        isr_set = 8'h00;
        isr_clr = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (ack) begin
                    state_d = ST_ACK;
                    lvl_d   = 3'd0;  // spurious acknowledge
                end else if (cand_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_ACK;
                    if (cand_valid) begin
                        lvl_d   = req_top;
                        isr_set = 8'b1 << req_top;
                    end else begin
                        lvl_d = 3'd0;
                    end
                end else if (!cand_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (cpu_iorq_n) begin
                    state_d = ST_IDLE;
`ifdef HC21_INT_AUTO_EOI_EN
                    isr_clr = 8'b1 << lvl_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifndef HC21_INT_AUTO_EOI_EN
        // EOI acts once per write strobe; with nothing in service it clears nothing.
        if (wr_start && isr_sel && (isr_q != 8'h00)) begin
            isr_clr = isr_clr | (8'b1 << isr_top);
        end
`endif
    end

    // Set wins over clear on the same bit.
    assign isr_d  = ((isr_q & ~isr_clr) | isr_set) & 8'hFE;
    assign mask_d = (io_wr && mask_sel) ? (cpu_data_in & 8'hFE) : mask_q;

    always_comb begin
        data_oe_d  = 1'b0;
        data_out_d = 8'h00;
        if (state_d == ST_ACK) begin
            data_oe_d  = 1'b1;
            data_out_d = {VEC_BASE[7:4], lvl_d, 1'b0};
        end else if (io_rd && mask_sel) begin
            data_oe_d  = 1'b1;
            data_out_d = mask_q;
        end else if (io_rd && isr_sel) begin
            data_oe_d  = 1'b1;
            data_out_d = isr_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q    <= 8'hFF;
            sync2_q    <= 8'hFF;
            mask_q     <= 8'h00;
            isr_q      <= 8'h00;
            state_q    <= ST_IDLE;
            lvl_q      <= 3'd0;
            io_wr_q    <= 1'b0;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
        end else begin
            sync1_q    <= atnrq_n;
            sync2_q    <= sync1_q;
            mask_q     <= mask_d;
            isr_q      <= isr_d;
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            io_wr_q    <= io_wr;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign cpu_data_out = data_out_q;
    assign cpu_data_oe  = data_oe_q;
    assign cpu_int_n    = state_q != ST_REQ;

endmodule

// File: tb/tb_hc21_int_ack_ctrl.sv
// Bench for hc21_int_ack_ctrl: directed scenarios followed by random bus transactions,
// all compared against a transaction-level model of mask, in-service set and asserted lines.
module tb_hc21_int_ack_ctrl;

    localparam logic [7:0] VEC_BASE = 8'h80;
    localparam logic [7:0] REG_BASE = 8'h20;
    localparam logic [7:0] REG_ISR  = 8'h21;
`ifdef HC21_INT_AUTO_EOI_EN
    localparam bit AUTO_EOI = 1'b1;
`else
    localparam bit AUTO_EOI = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic [7:0] atnrq_n;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_data_in;
    logic       cpu_m1_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0] cpu_data_out;
    logic       cpu_data_oe;
    logic       cpu_int_n;

    always #5 sysclk = ~sysclk;

    hc21_int_ack_ctrl #(
        .VEC_BASE(VEC_BASE),
        .REG_BASE(REG_BASE)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .atnrq_n     (atnrq_n),
        .cpu_addr    (cpu_addr),
        .cpu_data_in (cpu_data_in),
        .cpu_m1_n    (cpu_m1_n),
        .cpu_iorq_n  (cpu_iorq_n),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_data_out(cpu_data_out),
        .cpu_data_oe (cpu_data_oe),
        .cpu_int_n   (cpu_int_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: lines currently asserted (active high), MASK and in-service set.
    logic [7:0] m_lines, m_mask, m_isr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int highest(input logic [7:0] v);
        int h = 0;
        for (int i = 1; i < 8; i++) if (v[i]) h = i;
        return h;
    endfunction

    // Level that should be interrupting now, 0 if none.
    function automatic int m_cand();
        int r = highest(m_lines & m_mask);
        int s = highest(m_isr);
        return (r > s) ? r : 0;
    endfunction

    function automatic logic [7:0] vec_of(input int lvl);
        logic [2:0] l = lvl[2:0];
        return {VEC_BASE[7:4], l, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic set_lines(input logic [7:0] l);
        atnrq_n = ~l;  // bit 0 may be driven too; it must be ignored
        m_lines = l & 8'hFE;
    endtask

    task automatic settle_check(input string tag);
        cyc(4);
        check_val(tag, cpu_int_n, (m_cand() == 0) ? 1 : 0);
    endtask

    // Strobe held two cycles so a repeated EOI action would be visible.
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        cpu_addr = addr;
        cpu_data_in = data;
        cpu_iorq_n = 1'b0;
        cpu_wr_n = 1'b0;
        cyc(2);
        cpu_iorq_n = 1'b1;
        cpu_wr_n = 1'b1;
        cyc(1);
        if (addr == REG_BASE) m_mask = data & 8'hFE;
        if (addr == REG_ISR && !AUTO_EOI && m_isr != 8'h00) m_isr[highest(m_isr)] = 1'b0;
    endtask

    task automatic io_read(input string tag, input logic [7:0] addr);
        bit         hit = (addr == REG_BASE) || (addr == REG_ISR);
        logic [7:0] exp = (addr == REG_BASE) ? m_mask : m_isr;
        cpu_addr = addr;
        cpu_iorq_n = 1'b0;
        cpu_rd_n = 1'b0;
        cyc(1);
        check_val({tag, "_oe"}, cpu_data_oe, hit);
        if (hit) check_val({tag, "_data"}, cpu_data_out, exp);
        cpu_iorq_n = 1'b1;
        cpu_rd_n = 1'b1;
        cyc(1);
        check_val({tag, "_oe_off"}, cpu_data_oe, 0);
    endtask

    task automatic int_ack(input string tag);
        int c = m_cand();
        cpu_m1_n = 1'b0;
        cpu_iorq_n = 1'b0;
        cyc(1);
        check_val({tag, "_oe"}, cpu_data_oe, 1);
        check_val({tag, "_vec"}, cpu_data_out, vec_of(c));
        check_val({tag, "_int_hi"}, cpu_int_n, 1);
        cyc(1);
        check_val({tag, "_oe_hold"}, cpu_data_oe, 1);
        cpu_m1_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cyc(1);
        check_val({tag, "_oe_off"}, cpu_data_oe, 0);
        if (c != 0 && !AUTO_EOI) m_isr[c] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        atnrq_n = 8'hFF;
        cpu_addr = 8'h00;
        cpu_data_in = 8'h00;
        cpu_m1_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
        m_lines = 8'h00;
        m_mask = 8'h00;
        m_isr = 8'h00;
        cyc(3);
        check_val("rst_int_n", cpu_int_n, 1);
        check_val("rst_oe", cpu_data_oe, 0);
        check_val("rst_dout", cpu_data_out, 0);
        reset = 1'b0;
        cyc(1);
        io_read("rst_mask", REG_BASE);
        io_read("rst_isr", REG_ISR);

        // All levels masked: line 1 never interrupts.
        set_lines(8'h02);
        cyc(20);
        check_val("masked_int_n", cpu_int_n, 1);
        set_lines(8'h00);
        settle_check("released");

        // Three-cycle latency from line to INT, then acknowledge of level 3.
        io_write(REG_BASE, 8'hFF);
        io_read("mask_fe", REG_BASE);
        set_lines(8'h08);
        cyc(1);
        check_val("lat_c1", cpu_int_n, 1);
        cyc(1);
        check_val("lat_c2", cpu_int_n, 1);
        cyc(1);
        check_val("lat_c3", cpu_int_n, 0);
        int_ack("ack_l3");
        io_read("isr_l3", REG_ISR);
        settle_check("l3_in_service");

        // Nesting: level 6 on top of level 3, then two EOIs.
        set_lines(8'h48);
        settle_check("l6_int");
        int_ack("ack_l6");
        io_read("isr_l36", REG_ISR);
        io_write(REG_ISR, 8'h5A);
        io_read("isr_eoi1", REG_ISR);
        io_write(REG_ISR, 8'h00);
        io_read("isr_eoi2", REG_ISR);
        set_lines(8'h00);
        settle_check("idle_after_nest");
        if (!AUTO_EOI) begin
            io_write(REG_ISR, 8'h00);
            io_read("isr_eoi_empty", REG_ISR);
        end

        // Simultaneous lines 2 and 5.
        set_lines(8'h24);
        settle_check("l25_int");
        int_ack("ack_l5");
        io_write(REG_ISR, 8'h00);
        set_lines(8'h04);
        settle_check("l2_int");
        int_ack("ack_l2");
        io_write(REG_ISR, 8'h00);
        set_lines(8'h00);
        settle_check("idle_l2");

        // Short pulse on line 4, released before any acknowledge; later ack is spurious.
        set_lines(8'h10);
        cyc(3);
        check_val("pulse_int_lo", cpu_int_n, 0);
        set_lines(8'h00);
        settle_check("pulse_released");
        int_ack("ack_spurious");
        io_read("isr_spurious", REG_ISR);

        // Masking an in-service level keeps it in service.
        set_lines(8'h80);
        settle_check("l7_int");
        int_ack("ack_l7");
        io_write(REG_BASE, 8'h00);
        io_read("isr_masked_l7", REG_ISR);
        set_lines(8'h00);
        io_write(REG_ISR, 8'h00);
        io_write(REG_BASE, 8'hFE);

        // Random bus traffic against the model.
        for (int it = 0; it < 250; it++) begin
            logic [7:0] a;
            case ($urandom_range(0, 5))
                0: set_lines(8'($urandom));
                1: io_write(REG_BASE, 8'($urandom) | 8'h30);
                2: io_write(REG_ISR, 8'($urandom));
                3: int_ack("rnd_ack");
                4: io_read("rnd_rd", ($urandom_range(0, 1) == 0) ? REG_BASE : REG_ISR);
                default: begin
                    a = 8'($urandom);
                    if (a == REG_BASE || a == REG_ISR) a = 8'h55;
                    io_read("rnd_rd_other", a);
                end
            endcase
            settle_check("rnd_int_n");
        end

        // Reset in the middle of an acknowledge cycle.
        io_write(REG_BASE, 8'hFE);
        set_lines(8'h80);
        settle_check("pre_rst_int");
        cpu_m1_n = 1'b0;
        cpu_iorq_n = 1'b0;
        cyc(1);
        check_val("midack_oe", cpu_data_oe, 1);
        reset = 1'b1;
        cyc(1);
        check_val("midack_rst_oe", cpu_data_oe, 0);
        check_val("midack_rst_int", cpu_int_n, 1);
        cpu_m1_n = 1'b1;
        cpu_iorq_n = 1'b1;
        set_lines(8'h00);
        m_mask = 8'h00;
        m_isr = 8'h00;
        reset = 1'b0;
        cyc(1);
        io_read("post_rst_isr", REG_ISR);
        io_read("post_rst_mask", REG_BASE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
